// File: rtl/pulse_chain_gen.sv
// Purpose : multi-rate tick generator; a prescaler makes a base tick and a chain
//           of modulo-STAGE_DIV digit counters makes progressively slower pulses.
// Latency : all outputs registered; pulses and digit updates appear on the same
//           edge as the carry that causes them.
// Backpressure: none; en_i low freezes every counter (pause), clr_i restarts.
//
// Ports:
//   clk, rst    - system clock, synchronous active-high reset
//   en_i        - count enable (level)
//   clr_i       - synchronous restart, same effect as rst
//   oneshot_i   - stop after first top-stage pulse when high
//   pulse_o     - bit k is a one-cycle pulse every BASE_DIV*STAGE_DIV^k cycles
//   digits_o    - slice k is the stage-k digit (count of pulse_o[k] mod STAGE_DIV)
//   running_o   - high while armed, low once a one-shot run has completed
module pulse_chain_gen #(
  parameter int BASE_DIV   = 100_000_000,
  parameter int STAGE_DIV  = 10,
  parameter int NUM_STAGES = 2
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         en_i,
  input  logic                                         clr_i,
  input  logic                                         oneshot_i,
  output logic [NUM_STAGES-1:0]                        pulse_o,
  output logic [NUM_STAGES*$clog2(STAGE_DIV)-1:0]      digits_o,
  output logic                                         running_o
);

  localparam int PW = $clog2(BASE_DIV);
  localparam int DW = $clog2(STAGE_DIV);

  localparam logic [PW-1:0] PRE_TOP = PW'(BASE_DIV - 1);
  localparam logic [DW-1:0] DIG_TOP = DW'(STAGE_DIV - 1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_STOP = 1'b1
  } state_t;

  state_t                         state_q,   state_nxt;
  logic [PW-1:0]                  pre_cnt,   pre_nxt;
  logic [NUM_STAGES-1:0][DW-1:0]  dig,       dig_nxt;
  logic [NUM_STAGES-1:0]          pulse_q,   pulse_nxt;
  logic                           carry;

  // Next-state logic: clr_i beats advance; hold keeps counters but drops pulses.
  always_comb begin
    state_nxt = state_q;
    pre_nxt   = pre_cnt;
    dig_nxt   = dig;
    pulse_nxt = '0;
    carry     = 1'b0;

    if (clr_i) begin
      state_nxt = ST_RUN;
      pre_nxt   = '0;
      dig_nxt   = '0;
    end else if (state_q == ST_RUN && en_i) begin
      carry   = (pre_cnt == PRE_TOP);
      pre_nxt = carry ? '0 : pre_cnt + PW'(1);

      // Ripple the carry through the digit chain; every stage that receives a
      // carry pulses, so simultaneous pulses on several bits are expected.
      for (int k = 0; k < NUM_STAGES; k++) begin
        pulse_nxt[k] = carry;
        if (carry) begin
          dig_nxt[k] = (dig[k] == DIG_TOP) ? '0 : dig[k] + DW'(1);
        end
        carry = carry && (dig[k] == DIG_TOP);
      end

      // oneshot_i only matters on the edge that produces the top pulse.
      if (pulse_nxt[NUM_STAGES-1] && oneshot_i) begin
        state_nxt = ST_STOP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pre_cnt <= '0;
      dig     <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_nxt;
      pre_cnt <= pre_nxt;
      dig     <= dig_nxt;
      pulse_q <= pulse_nxt;
    end
  end

  assign pulse_o   = pulse_q;
  assign digits_o  = dig;
  assign running_o = (state_q == ST_RUN);

endmodule

// File: tb/tb_pulse_chain_gen.sv
module tb_pulse_chain_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_i = 1'b0;
  logic       clr_i = 1'b0;
  logic       oneshot_i = 1'b0;
  logic [2:0] pulse_o;
  logic [5:0] digits_o;
  logic       running_o;

  int checks = 0;
  int failures = 0;

  // Reference: count of enabled edges since the last rst/clr, plus armed flag.
  int   e_m = 0;
  logic run_m = 1'b1;

  pulse_chain_gen #(
    .BASE_DIV   (4),
    .STAGE_DIV  (3),
    .NUM_STAGES (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en_i),
    .clr_i     (clr_i),
    .oneshot_i (oneshot_i),
    .pulse_o   (pulse_o),
    .digits_o  (digits_o),
    .running_o (running_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge with the currently driven inputs, then compare all outputs
  // against the edge-count model (periods 4, 12, 36 cycles).
  task automatic step(input string tag);
    logic       adv;
    logic [2:0] ep;
    logic [5:0] ed;
    adv = 1'b0;
    if (rst || clr_i) begin
      e_m   = 0;
      run_m = 1'b1;
    end else if (run_m && en_i) begin
      e_m++;
      adv = 1'b1;
    end
    ep = 3'b000;
    if (adv) begin
      ep[0] = (e_m % 4  == 0);
      ep[1] = (e_m % 12 == 0);
      ep[2] = (e_m % 36 == 0);
      if (ep[2] && oneshot_i) run_m = 1'b0;
    end
    ed = {2'((e_m / 36) % 3), 2'((e_m / 12) % 3), 2'((e_m / 4) % 3)};
    @(posedge clk);
    #1;
    chk({tag, ".pulse"},   32'(pulse_o),   32'(ep));
    chk({tag, ".digits"},  32'(digits_o),  32'(ed));
    chk({tag, ".running"}, 32'(running_o), 32'(run_m));
  endtask

  initial begin
    // Reset state
    rst = 1'b1; en_i = 1'b1;
    step("reset");
    chk("reset_pulse",   32'(pulse_o),   32'd0);
    chk("reset_digits",  32'(digits_o),  32'd0);
    chk("reset_running", 32'(running_o), 32'd1);

    // Free run, edges 1..40
    rst = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      step($sformatf("free_e%0d", n));
      if (n == 4)  chk("free_first_p0", 32'(pulse_o), 32'b001);
      if (n == 5)  chk("free_p0_width", 32'(pulse_o), 32'b000);
      if (n == 12) chk("free_first_p1", 32'(pulse_o), 32'b011);
      if (n == 36) begin
        chk("free_all_pulse", 32'(pulse_o),  32'b111);
        chk("free_digits36",  32'(digits_o), 32'b01_00_00);
      end
      if (n == 37) chk("free_p2_width", 32'(pulse_o), 32'b000);
    end

    // Pause: en_i low for edges 3..7
    rst = 1'b1; step("pause_rst"); rst = 1'b0;
    en_i = 1'b1; step("pause_e1"); step("pause_e2");
    en_i = 1'b0;
    for (int n = 3; n <= 7; n++) step($sformatf("pause_gap_e%0d", n));
    chk("pause_frozen_digits", 32'(digits_o), 32'd0);
    en_i = 1'b1;
    step("pause_e8");
    chk("pause_no_p_e8", 32'(pulse_o), 32'b000);
    step("pause_e9");
    chk("pause_p0_e9",     32'(pulse_o),  32'b001);
    chk("pause_digits_e9", 32'(digits_o), 32'd1);

    // Clear on edge 10 with en_i high
    rst = 1'b1; step("clr_rst"); rst = 1'b0;
    for (int n = 1; n <= 9; n++) step($sformatf("clr_e%0d", n));
    clr_i = 1'b1;
    step("clr_e10");
    chk("clr_no_pulse", 32'(pulse_o),  32'b000);
    chk("clr_digits",   32'(digits_o), 32'd0);
    clr_i = 1'b0;
    for (int n = 11; n <= 13; n++) step($sformatf("clr_e%0d", n));
    chk("clr_no_p_e13", 32'(pulse_o), 32'b000);
    step("clr_e14");
    chk("clr_p0_e14", 32'(pulse_o), 32'b001);

    // One-shot
    rst = 1'b1; step("os_rst"); rst = 1'b0;
    oneshot_i = 1'b1;
    for (int n = 1; n <= 35; n++) step($sformatf("os_e%0d", n));
    step("os_e36");
    chk("os_top_pulse",   32'(pulse_o),   32'b111);
    chk("os_stopped",     32'(running_o), 32'd0);
    chk("os_digits_stop", 32'(digits_o),  32'b01_00_00);
    for (int n = 37; n <= 100; n++) begin
      if (n == 50) oneshot_i = 1'b0;
      if (n == 60) en_i = 1'b0;
      if (n == 65) en_i = 1'b1;
      step($sformatf("os_hold_e%0d", n));
    end
    chk("os_still_stopped", 32'(running_o), 32'd0);
    clr_i = 1'b1;
    step("os_clr_e101");
    chk("os_rearmed", 32'(running_o), 32'd1);
    chk("os_clr_dig", 32'(digits_o),  32'd0);
    clr_i = 1'b0;
    for (int n = 102; n <= 104; n++) step($sformatf("os_e%0d", n));
    step("os_e105");
    chk("os_p0_e105", 32'(pulse_o), 32'b001);

    // Reset mid-run at edge 20
    rst = 1'b1; step("mid_rst0"); rst = 1'b0;
    for (int n = 1; n <= 19; n++) step($sformatf("mid_e%0d", n));
    rst = 1'b1;
    step("mid_rst_e20");
    chk("mid_rst_pulse",   32'(pulse_o),   32'd0);
    chk("mid_rst_digits",  32'(digits_o),  32'd0);
    chk("mid_rst_running", 32'(running_o), 32'd1);
    rst = 1'b0;
    for (int n = 1; n <= 3; n++) step($sformatf("mid_post_e%0d", n));
    step("mid_post_e4");
    chk("mid_post_p0", 32'(pulse_o), 32'b001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_chain_gen.md
# pulse_chain_gen

Parametrised multi-rate tick generator: a prescaler divides the system clock into a base tick, then a chain of identical modulo stages derives progressively slower one-cycle pulses. Each stage also exposes its current count. Supports pause, synchronous restart and one-shot (stop-on-top-pulse) mode. Sits beside the system clock, driving timers, display refresh and LED blink logic. Generalises the fixed 1 s / 10 s pulse counter to N stages with arbitrary divisors.

## Interface
- BASE_DIV, 100_000_000, clock cycles per base tick (pulse_o[0] period); legal ≥ 2
- STAGE_DIV, 10, ratio between consecutive stage periods; legal ≥ 2
- NUM_STAGES, 2, number of pulse outputs / digit counters; legal 1..8
- Derived: PW = $clog2(BASE_DIV); DW = $clog2(STAGE_DIV)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en_i  in  1  count enable (level); low freezes all state
- clr_i  in  1  synchronous restart: zero all counters, re-arm
- oneshot_i  in  1  1 = stop after first pulse_o[NUM_STAGES-1]; 0 = free-run
- pulse_o  out  NUM_STAGES  bit k: one-cycle pulse, period BASE_DIV·STAGE_DIV^k cycles
- digits_o  out  NUM_STAGES·DW  slice k = count of pulse_o[k] events mod STAGE_DIV
- running_o  out  1  1 while generator is armed (not stopped by one-shot)

## Operation
- State: prescaler pre_cnt[PW-1:0], digit counters dig[k][DW-1:0], running flag. All outputs registered.
- Reset (rst=1): pre_cnt=0, all dig=0, pulse_o=0, digits_o=0, running_o=1.
- Priority per edge: rst > clr_i > (running & en_i) > hold.
- clr_i: same effect as rst (running_o←1); no pulse that cycle, regardless of en_i.
- Advance (running & en_i):
  - pre_cnt < BASE_DIV-1: pre_cnt+1, pulse_o←0.
  - pre_cnt == BASE_DIV-1: pre_cnt←0, pulse_o[0]←1 (carry into stage 0).
  - Stage k with carry in: dig[k] increments mod STAGE_DIV; if dig[k] was STAGE_DIV-1 it wraps to 0 and pulse_o[k+1]←1 (carry to stage k+1).
  - Top stage dig wraps silently; no carry out.
- Hold (en_i=0 or stopped): all counters retain value, pulse_o←0. Resume continues from held count with no lost or extra cycles.
- One-shot: if oneshot_i=1 on the edge that sets pulse_o[NUM_STAGES-1], running_o←0 on that same edge. Counters then frozen (lower stages 0, top digit 1). Only rst or clr_i re-arms; en_i and changes of oneshot_i have no effect while stopped.
- oneshot_i sampled only on the top-carry edge; may change freely otherwise.

## Timing
- Cycle n = nth rising edge after rst deasserts with en_i=1 continuously.
- pulse_o[0] high during the cycle after edges n = BASE_DIV·m (m≥1); width exactly 1 cycle.
- pulse_o[k] high after edges n = BASE_DIV·STAGE_DIV^k·m; coincides with pulse_o[0..k-1] in the same cycle (simultaneous carries are the norm, not a conflict).
- digits_o updates on the same edge as the pulse that caused it; zero extra latency.
- Pause of P cycles delays every subsequent pulse by exactly P cycles.
- clr_i asserted on edge c: next pulse_o[0] after edge c+BASE_DIV (with en_i=1).
- Degenerate NUM_STAGES=1: only prescaler + dig[0]; top pulse = pulse_o[0].

## Test plan
- Params BASE_DIV=4, STAGE_DIV=3, NUM_STAGES=3, free-run: pulse_o[0] after edges 4,8,12,…; pulse_o[1] after 12,24; pulse_o[2] after 36 with pulse_o=3'b111 that cycle; digits_o slices 0,0,1 after edge 36; all pulses exactly 1 cycle wide.
- Same params, en_i low for 5 cycles starting after edge 2: first pulse_o[0] after edge 9; digits_o and pre_cnt frozen during gap.
- clr_i on edge 10 (en_i=1 simultaneously): no pulse after edge 10, digits_o=0, next pulse_o[0] after edge 14.
- oneshot_i=1: pulse_o[2] after edge 36, running_o=0 from then; no further pulses through edge 100 even with en_i=1; clr_i on edge 101 → running_o=1, pulse_o[0] after edge 105.
- rst asserted mid-run (edge 20): all outputs 0, running_o=1 after that edge; counting restarts, pulse_o[0] after 4 enabled edges post-deassertion.
- Default params (100 MHz): pulse_o[0] at 1e8-cycle interval, pulse_o[1] at 1e9; check first two occurrences of each.
